// File: rtl/blc_pkg.sv
// +--------------------------------------------------------------------------+
// | blc_pkg : shared types and constants for the black-level trimmed mean.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package blc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int NUM_ELEM   = 64;
  localparam int MEDIAN_IDX = 32;

  // Samples discarded at each end when 2^keep_log2 central samples are kept.
  function automatic int trim_of(input int keep_log2);
    return (NUM_ELEM - (1 << keep_log2)) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blc_trim_mean.sv
// +--------------------------------------------------------------------------+
// | blc_trim_mean : trimmed mean and upper median of a sorted 64-sample      |
// | vector. Define BLC_ROUND_EN for round-half-up, else truncation. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module blc_trim_mean
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_LOG2  = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] idata,
  input  logic                           ivalid,
  output logic                           busy,
  output logic [DATA_WIDTH-1:0]          odata,
  output logic [DATA_WIDTH-1:0]          omedian,
  output logic                           ovalid
);

  localparam int KEEP  = 1 << KEEP_LOG2;
  localparam int TRIM  = trim_of(KEEP_LOG2);
  localparam int ACC_W = DATA_WIDTH + KEEP_LOG2;
  localparam int CNT_W = (KEEP_LOG2 == 0) ? 1 : KEEP_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEEP - 1);
  // Half an LSB of the result; KEEP>>1 is 0 when only one sample is kept.
  localparam logic [ACC_W-1:0] RND = ACC_W'(KEEP >> 1);

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] buffer [NUM_ELEM];
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      cnt;
  logic [5:0]            sel_idx;
  logic [DATA_WIDTH-1:0] elem;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] result;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ivalid) state_nx = ACC;
      ACC:     if (cnt == CNT_LAST) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------- datapath ----------------
  // TRIM+cnt never exceeds NUM_ELEM-1, so a 6-bit index is exact.
  assign sel_idx = 6'(TRIM) + 6'(cnt);
  assign elem    = buffer[sel_idx];

`ifdef BLC_ROUND_EN
  // Cannot overflow ACC_W bits: acc <= KEEP*(2^DW-1) and RND < KEEP.
  assign sum = acc + RND;
`else
  assign sum = acc;
`endif

  assign result = DATA_WIDTH'(sum >> KEEP_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) buffer[i] <= '0;
      acc     <= '0;
      cnt     <= '0;
      odata   <= '0;
      omedian <= '0;
      ovalid  <= 1'b0;
    end else begin
      ovalid <= 1'b0;
      case (state)
        IDLE: begin
          if (ivalid) begin
            for (int i = 0; i < NUM_ELEM; i++)
              buffer[i] <= idata[i*DATA_WIDTH +: DATA_WIDTH];
            acc <= '0;
            cnt <= '0;
          end
        end
        ACC: begin
          acc <= acc + ACC_W'(elem);
          cnt <= cnt + 1'b1;
        end
        OUT: begin
          odata   <= result;
          omedian <= buffer[MEDIAN_IDX];
          ovalid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blc_trim_mean.sv
// Scoreboard bench for blc_trim_mean (DATA_WIDTH=8, KEEP_LOG2=5).
`default_nettype none

module tb_blc_trim_mean;

  localparam int DW = 8;
  localparam int NE = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NE*DW-1:0] idata = '0;
  logic             ivalid = 1'b0;
  logic             busy;
  logic [DW-1:0]    odata;
  logic [DW-1:0]    omedian;
  logic             ovalid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] mean;
    logic [DW-1:0] med;
  } exp_t;

  exp_t exp_q[$];

  blc_trim_mean #(.DATA_WIDTH(8), .KEEP_LOG2(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .idata   (idata),
    .ivalid  (ivalid),
    .busy    (busy),
    .odata   (odata),
    .omedian (omedian),
    .ovalid  (ovalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every ovalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ovalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ovalid: got odata=%0d expected no output", odata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("odata", int'(odata), int'(e.mean));
        check("omedian", int'(omedian), int'(e.med));
      end
    end
  end

  function automatic logic [NE*DW-1:0] const_vec(input logic [DW-1:0] val);
    logic [NE*DW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = val;
    return v;
  endfunction

  // Present one vector for a single cycle; returns at the negedge after the sampling edge.
  task automatic send(input logic [NE*DW-1:0] v);
    @(negedge clk);
    idata  = v;
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
  endtask

  // Counts cycles from the sampling edge until ovalid is seen, and busy cycles on the way.
  task automatic wait_ovalid(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ovalid) begin
        lat = n;
        return;
      end
      if (busy) busy_cnt++;
    end
    total++;
    bad++;
    $display("FAIL ovalid_timeout: got no ovalid within 60 cycles expected one");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [NE*DW-1:0] v;
    int lat, bc;
    int ramp_exp;

`ifdef BLC_ROUND_EN
    ramp_exp = 32;
`else
    ramp_exp = 31;
`endif

    // Reset state
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_ovalid", int'(ovalid), 0);
    check("rst_odata", int'(odata), 0);
    check("rst_omedian", int'(omedian), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Flat 0x40: latency and busy duration
    exp_q.push_back('{mean: 8'h40, med: 8'h40});
    send(const_vec(8'h40));
    wait_ovalid(lat, bc);
    check("latency", lat, 33);
    check("busy_cycles", bc, 33);
    idle(1);
    check("busy_after", int'(busy), 0);
    check("ovalid_pulse", int'(ovalid), 0);
    check("odata_hold", int'(odata), 8'h40);

    // Ramp 0..63: kept sum 1008
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(i);
    exp_q.push_back('{mean: DW'(ramp_exp), med: 8'd32});
    send(v);
    wait_ovalid(lat, bc);
    idle(2);

    // Outlier rejection
    for (int i = 0; i < NE; i++)
      v[i*DW +: DW] = (i < 16) ? 8'h00 : (i < 48) ? 8'h10 : 8'hFF;
    exp_q.push_back('{mean: 8'h10, med: 8'h10});
    send(v);
    wait_ovalid(lat, bc);
    idle(2);

    // Full scale, then back-to-back vector accepted in the ovalid cycle
    exp_q.push_back('{mean: 8'hFF, med: 8'hFF});
    send(const_vec(8'hFF));
    wait_ovalid(lat, bc);
    check("b2b_idle_in_ovalid", int'(busy), 0);
    exp_q.push_back('{mean: 8'h01, med: 8'h01});
    idata  = const_vec(8'h01);
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    check("b2b_accepted", int'(busy), 1);
    wait_ovalid(lat, bc);
    check("b2b_latency", lat, 33);
    idle(2);

    // ivalid re-pulsed in ACC cycle 5 must be ignored
    exp_q.push_back('{mean: 8'h20, med: 8'h20});
    send(const_vec(8'h20));
    idle(4);
    idata  = const_vec(8'h80);
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    wait_ovalid(lat, bc);
    check("repulse_latency", lat, 28);
    idle(40);

    // Reset in ACC cycle 10 abandons the computation
    send(const_vec(8'h33));
    idle(9);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_odata", int'(odata), 0);
    check("midrst_omedian", int'(omedian), 0);
    check("midrst_ovalid", int'(ovalid), 0);
    idle(2);
    rst_n = 1'b1;
    idle(40);

    // Element i = 2*i after reset: kept 32..94 evens, sum 2016
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(2 * i);
    exp_q.push_back('{mean: 8'd63, med: 8'd64});
    send(v);
    wait_ovalid(lat, bc);
    check("post_rst_latency", lat, 33);
    idle(3);

    check("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
